fir_output_verifier: RTL and testbench
======================================

FIR_OUTPUT_VERIFIER -- requirements
Module: fir_output_verifier

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning number of samples compared per run (1..255).
REQ-002 SHALL have parameter SKIP, default 4, meaning number of leading valid samples discarded as FIR warm-up (0..255).
REQ-003 SHALL have parameter BASE, default 16'sd0, meaning expected value of compared sample 0.
REQ-004 SHALL have parameter STEP, default 16'sd100, meaning expected increment per compared sample.
REQ-005 SHALL have parameter TOLERANCE, default 0, meaning maximum allowed absolute difference (0..32767).
REQ-006 SHALL have port system1000  input  1  clock; one clock domain; reset is synchronous and active-high.
REQ-007 SHALL have port system1000_rst  input  1  synchronous active-high reset.
REQ-008 SHALL have port start  input  1  one-cycle run request.
REQ-009 SHALL have port result  input  16 signed  FIR output sample.
REQ-010 SHALL have port result_valid  input  1  result qualifier.
REQ-011 SHALL have port busy  output  1  run in progress.
REQ-012 SHALL have port done  output  1  run finished; held until next start or reset.
REQ-013 SHALL have port pass  output  1  done with zero mismatches.
REQ-014 SHALL have port error_count  output  8  mismatch count, saturating.
REQ-015 SHALL have port sample_index  output  8  index of next compared sample.

Function
REQ-016 SHALL implement states IDLE, SKIP, CHECK, DONE; busy=1 in SKIP and CHECK only.
REQ-017 SHALL, on start in IDLE or DONE, clear error_count, sample_index, skip counter, done, pass, and enter SKIP, or CHECK directly if SKIP=0.
REQ-018 SHALL ignore start while busy.
REQ-019 SHALL, in SKIP, count valid samples without comparison and enter CHECK on the cycle the SKIP-th valid sample is accepted.
REQ-020 SHALL, in CHECK, compare each valid sample against exp(i) = BASE + i*STEP, wrapped to 16 bits, where i = sample_index.
REQ-021 SHALL compute the difference in 17-bit signed arithmetic (no overflow) and flag mismatch when |result - exp(i)| > TOLERANCE.
REQ-022 SHALL increment error_count on mismatch, saturating at 255.
REQ-023 SHALL increment sample_index per valid sample in CHECK; after sample DEPTH-1 it SHALL enter DONE the next cycle.
REQ-024 SHALL update error_count and sample_index one cycle after the accepted sample (registered, latency 1).
REQ-025 SHALL, in DONE, assert done=1 and pass=(error_count==0), and ignore result_valid.
REQ-026 SHALL ignore result_valid in IDLE.
REQ-027 SHALL hold all state while result_valid=0 (gaps permitted, no timeout).

Reset
REQ-028 SHALL, on system1000_rst=1 at a clock edge, enter IDLE, with busy=0, done=0, pass=0, error_count=0, sample_index=0.
REQ-029 SHALL give reset priority over start and result_valid, including mid-run; the aborted run leaves no residue.

Configuration
REQ-030 SHALL compile first-failure capture when macro FIR_OUTPUT_VERIFIER_FIRST_FAIL_EN is defined: outputs first_fail_valid (1), first_fail_index (8), first_fail_value (16 signed) latch the index and received value of the first mismatch of a run, cleared on start and reset.
REQ-031 SHALL, without FIR_OUTPUT_VERIFIER_FIRST_FAIL_EN, omit those ports and registers entirely, with all other behaviour unchanged.

Verification
REQ-032 SHALL cover: defaults, start, 4 junk samples then 0,100,...,1500 -> done=1, pass=1, error_count=0, sample_index=16.
REQ-033 SHALL cover: same stream with compared sample 5 = 501, TOLERANCE=0 -> error_count=1, pass=0; with FIRST_FAIL_EN, first_fail_index=5, first_fail_value=501.
REQ-034 SHALL cover: TOLERANCE=2, samples offset by +2 -> pass=1; offset +3 -> error_count=16.
REQ-035 SHALL cover: BASE=32767, STEP=1 -> sample 1 expected -32768 (wrap), and result=-32768 at TOLERANCE=0 -> no mismatch.
REQ-036 SHALL cover: reset asserted after 7 compared samples with 2 errors -> next cycle IDLE, error_count=0; new start yields a clean run.
REQ-037 SHALL cover: start pulsed mid-CHECK and result_valid gaps of 3 cycles -> no restart, counts unchanged by gaps, run completes normally.

Source files
------------

// File: rtl/fir_output_verifier.sv
// fir_output_verifier
//
// Checks the output stream of a FIR filter against a linear ramp.
// A run starts with a one-cycle start pulse. The first SKIP valid samples
// are discarded as filter warm-up. The next DEPTH valid samples are compared
// against exp(i) = BASE + i*STEP, wrapped to 16 bits. A sample mismatches
// when it differs from exp(i) by more than TOLERANCE.
//
// Ports
//   system1000      clock (single domain)
//   system1000_rst  synchronous active-high reset
//   start           one-cycle run request; ignored while busy
//   result          signed 16-bit FIR output sample
//   result_valid    qualifies result
//   busy            high while skipping or checking
//   done            run finished; held until the next start or reset
//   pass            done with zero mismatches
//   error_count     saturating mismatch count
//   sample_index    index of the next compared sample
//
// Optional feature (macro FIR_OUTPUT_VERIFIER_FIRST_FAIL_EN)
//   first_fail_valid  a mismatch has been captured in this run
//   first_fail_index  sample index of the first mismatch
//   first_fail_value  received value of the first mismatch
module fir_output_verifier #(
    parameter int                 DEPTH     = 16,
    parameter int                 SKIP      = 4,
    parameter logic signed [15:0] BASE      = 16'sd0,
    parameter logic signed [15:0] STEP      = 16'sd100,
    parameter int                 TOLERANCE = 0
) (
    input  logic               system1000,
    input  logic               system1000_rst,
    input  logic               start,
    input  logic signed [15:0] result,
    input  logic               result_valid,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [7:0]         error_count,
    output logic [7:0]         sample_index
`ifdef FIR_OUTPUT_VERIFIER_FIRST_FAIL_EN
    ,
    output logic               first_fail_valid,
    output logic [7:0]         first_fail_index,
    output logic signed [15:0] first_fail_value
`endif
);

    localparam logic [7:0]  LAST_IDX  = 8'(DEPTH - 1);
    localparam logic [7:0]  SKIP_LAST = 8'(SKIP - 1);
    localparam logic [16:0] TOL_MAG   = 17'(TOLERANCE);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SKIP,
        ST_CHECK,
        ST_DONE
    } state_t;

    state_t             state;
    logic [7:0]         skip_count;
    // Running expected value: advancing by STEP per compared sample gives
    // BASE + i*STEP wrapped to 16 bits without needing a multiplier.
    logic signed [15:0] expected;

    logic signed [16:0] diff;
    logic [16:0]        diff_mag;
    logic               mismatch;
    logic [7:0]         error_next;

    // Compare the incoming sample with the expected value. Both operands are
    // sign-extended to 17 bits so the difference can never overflow; the
    // magnitude is then held as a 17-bit unsigned value (max 65535).
    always_comb begin
        diff       = {result[15], result} - {expected[15], expected};
        diff_mag   = diff[16] ? -diff : diff;
        mismatch   = diff_mag > TOL_MAG;
        error_next = error_count;
        if (mismatch && (error_count != 8'hFF)) begin
            error_next = error_count + 8'd1;
        end
    end

    // Run controller. All outputs are registered here so that counts appear
    // one cycle after the sample that caused them, and done/pass appear on
    // the cycle after the last compared sample.
    always_ff @(posedge system1000) begin
        if (system1000_rst) begin
            state        <= ST_IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            error_count  <= 8'd0;
            sample_index <= 8'd0;
            skip_count   <= 8'd0;
            expected     <= BASE;
`ifdef FIR_OUTPUT_VERIFIER_FIRST_FAIL_EN
            first_fail_valid <= 1'b0;
            first_fail_index <= 8'd0;
            first_fail_value <= 16'sd0;
`endif
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        error_count  <= 8'd0;
                        sample_index <= 8'd0;
                        skip_count   <= 8'd0;
                        expected     <= BASE;
                        done         <= 1'b0;
                        pass         <= 1'b0;
                        busy         <= 1'b1;
                        state        <= (SKIP == 0) ? ST_CHECK : ST_SKIP;
`ifdef FIR_OUTPUT_VERIFIER_FIRST_FAIL_EN
                        first_fail_valid <= 1'b0;
                        first_fail_index <= 8'd0;
                        first_fail_value <= 16'sd0;
`endif
                    end
                end
                ST_SKIP: begin
                    if (result_valid) begin
                        skip_count <= skip_count + 8'd1;
                        if (skip_count == SKIP_LAST) begin
                            state <= ST_CHECK;
                        end
                    end
                end
                ST_CHECK: begin
                    if (result_valid) begin
                        error_count  <= error_next;
                        sample_index <= sample_index + 8'd1;
                        expected     <= expected + STEP;
`ifdef FIR_OUTPUT_VERIFIER_FIRST_FAIL_EN
                        if (mismatch && !first_fail_valid) begin
                            first_fail_valid <= 1'b1;
                            first_fail_index <= sample_index;
                            first_fail_value <= result;
                        end
`endif
                        if (sample_index == LAST_IDX) begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (error_next == 8'd0);
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_output_verifier.sv
// Testbench for fir_output_verifier.
// Three instances share one stimulus stream: defaults, TOLERANCE=2, and
// BASE=32767/STEP=1. A reference model keeps the list of compared samples
// of the current run and derives every expected output from it.
module tb_fir_output_verifier;

    localparam int SKIP  = 4;
    localparam int DEPTH = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic signed [15:0] result;
    logic               result_valid;

    logic       busy0, done0, pass0, busy1, done1, pass1, busy2, done2, pass2;
    logic [7:0] errc0, sidx0, errc1, sidx1, errc2, sidx2;
`ifdef FIR_OUTPUT_VERIFIER_FIRST_FAIL_EN
    logic               ffv0, ffv1, ffv2;
    logic [7:0]         ffi0, ffi1, ffi2;
    logic signed [15:0] ffd0, ffd1, ffd2;
`endif

    int compared   = 0;
    int mismatched = 0;

    // Model state: is a run active, has it finished, how many valid samples
    // it accepted, and which samples fell into the compared window.
    bit run_active = 0;
    bit run_done   = 0;
    int accepted   = 0;
    int cmp_q[$];
    int stim_q[$];

    always #5 clk = ~clk;

    fir_output_verifier dut0 (
        .system1000(clk), .system1000_rst(rst), .start(start),
        .result(result), .result_valid(result_valid),
        .busy(busy0), .done(done0), .pass(pass0),
        .error_count(errc0), .sample_index(sidx0)
`ifdef FIR_OUTPUT_VERIFIER_FIRST_FAIL_EN
        , .first_fail_valid(ffv0), .first_fail_index(ffi0), .first_fail_value(ffd0)
`endif
    );

    fir_output_verifier #(.TOLERANCE(2)) dut1 (
        .system1000(clk), .system1000_rst(rst), .start(start),
        .result(result), .result_valid(result_valid),
        .busy(busy1), .done(done1), .pass(pass1),
        .error_count(errc1), .sample_index(sidx1)
`ifdef FIR_OUTPUT_VERIFIER_FIRST_FAIL_EN
        , .first_fail_valid(ffv1), .first_fail_index(ffi1), .first_fail_value(ffd1)
`endif
    );

    fir_output_verifier #(.BASE(16'sd32767), .STEP(16'sd1)) dut2 (
        .system1000(clk), .system1000_rst(rst), .start(start),
        .result(result), .result_valid(result_valid),
        .busy(busy2), .done(done2), .pass(pass2),
        .error_count(errc2), .sample_index(sidx2)
`ifdef FIR_OUTPUT_VERIFIER_FIRST_FAIL_EN
        , .first_fail_valid(ffv2), .first_fail_index(ffi2), .first_fail_value(ffd2)
`endif
    );

    // Count one comparison and report it when observed differs from expected.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        compared++;
        if (observed != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    // Expected value of compared sample i, wrapped to a signed 16-bit value.
    function automatic int exp_val(input int base, input int step, input int i);
        logic signed [15:0] w;
        w = 16'(base + i * step);
        return int'(w);
    endfunction

    function automatic bit is_bad(input int value, input int expv, input int tol);
        int d;
        d = value - expv;
        if (d < 0) d = -d;
        return d > tol;
    endfunction

    function automatic int count_err(input int base, input int step, input int tol);
        int n = 0;
        foreach (cmp_q[i]) if (is_bad(cmp_q[i], exp_val(base, step, i), tol)) n++;
        return (n > 255) ? 255 : n;
    endfunction

    task automatic checkInst(input string name, input logic b, input logic d, input logic p,
                             input logic [7:0] ec, input logic [7:0] si,
                             input int base, input int step, input int tol);
        int err;
        err = count_err(base, step, tol);
        checkOutput({name, ".busy"}, int'(b), int'(run_active));
        checkOutput({name, ".done"}, int'(d), int'(run_done));
        checkOutput({name, ".pass"}, int'(p), int'(run_done && err == 0));
        checkOutput({name, ".error_count"}, int'(ec), err);
        checkOutput({name, ".sample_index"}, int'(si), cmp_q.size());
    endtask

`ifdef FIR_OUTPUT_VERIFIER_FIRST_FAIL_EN
    task automatic checkFirst(input string name, input logic v, input logic [7:0] idx,
                              input logic signed [15:0] val,
                              input int base, input int step, input int tol);
        int fi = -1;
        int fv = 0;
        foreach (cmp_q[i]) begin
            if (fi < 0 && is_bad(cmp_q[i], exp_val(base, step, i), tol)) begin
                fi = i;
                fv = cmp_q[i];
            end
        end
        checkOutput({name, ".first_fail_valid"}, int'(v), int'(fi >= 0));
        checkOutput({name, ".first_fail_index"}, int'(idx), (fi >= 0) ? fi : 0);
        checkOutput({name, ".first_fail_value"}, int'(val), fv);
    endtask
`endif

    // Drive one clock cycle of inputs, advance the model, then check all
    // instances shortly after the edge.
    task automatic applyStimulus(input bit st, input bit vld, input logic signed [15:0] val,
                                 input bit rs);
        start        = st;
        result_valid = vld;
        result       = val;
        rst          = rs;
        @(posedge clk);
        if (rs) begin
            run_active = 0;
            run_done   = 0;
            accepted   = 0;
            cmp_q.delete();
        end else if (st && !run_active) begin
            run_active = 1;
            run_done   = 0;
            accepted   = 0;
            cmp_q.delete();
        end else if (run_active && vld) begin
            if (accepted >= SKIP) cmp_q.push_back(int'(val));
            accepted++;
            if (accepted == SKIP + DEPTH) begin
                run_active = 0;
                run_done   = 1;
            end
        end
        #1;
        checkInst("def", busy0, done0, pass0, errc0, sidx0, 0, 100, 0);
        checkInst("tol", busy1, done1, pass1, errc1, sidx1, 0, 100, 2);
        checkInst("wrap", busy2, done2, pass2, errc2, sidx2, 32767, 1, 0);
`ifdef FIR_OUTPUT_VERIFIER_FIRST_FAIL_EN
        checkFirst("def", ffv0, ffi0, ffd0, 0, 100, 0);
        checkFirst("tol", ffv1, ffi1, ffd1, 0, 100, 2);
        checkFirst("wrap", ffv2, ffi2, ffd2, 32767, 1, 0);
`endif
    endtask

    // Junk warm-up samples followed by a ramp i*100 + offset.
    task automatic buildLinear(input int offset);
        stim_q.delete();
        for (int i = 0; i < SKIP; i++) stim_q.push_back(int'($signed(16'($urandom))));
        for (int i = 0; i < DEPTH; i++) stim_q.push_back(i * 100 + offset);
    endtask

    // Start a run and feed stim_q with a fixed gap of idle cycles before
    // each sample. At sample position mid_start, start is pulsed together
    // with the sample. Two trailing valid cycles exercise DONE ignoring data.
    task automatic play(input int gap, input int mid_start);
        applyStimulus(1, 0, 16'sd0, 0);
        for (int i = 0; i < stim_q.size(); i++) begin
            for (int g = 0; g < gap; g++) applyStimulus(0, 0, 16'($urandom), 0);
            applyStimulus(i == mid_start, 1, 16'(stim_q[i]), 0);
        end
        applyStimulus(0, 1, 16'($urandom), 0);
        applyStimulus(0, 1, 16'($urandom), 0);
    endtask

    initial begin
        start = 0; result_valid = 0; result = 0; rst = 1;

        // Reset, then valid data in IDLE must be ignored.
        applyStimulus(0, 0, 16'sd0, 1);
        applyStimulus(0, 0, 16'sd0, 1);
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 16'($urandom), 0);

        // Clean ramp.
        buildLinear(0);
        play(0, -1);

        // Compared sample 5 = 501.
        buildLinear(0);
        stim_q[SKIP + 5] = 501;
        play(0, -1);

        // Offsets of +2 and +3 around the tolerance edge.
        buildLinear(2);
        play(0, -1);
        buildLinear(3);
        play(0, -1);

        // Wrapping ramp starting at 32767.
        stim_q.delete();
        for (int i = 0; i < SKIP; i++) stim_q.push_back(int'($signed(16'($urandom))));
        for (int i = 0; i < DEPTH; i++) stim_q.push_back(exp_val(32767, 1, i));
        play(0, -1);

        // Reset after 7 compared samples with 2 errors, then a clean run.
        applyStimulus(1, 0, 16'sd0, 0);
        for (int i = 0; i < SKIP; i++) applyStimulus(0, 1, 16'($urandom), 0);
        for (int i = 0; i < 7; i++) applyStimulus(0, 1, 16'(i * 100 + ((i == 2 || i == 4) ? 50 : 0)), 0);
        applyStimulus(1, 1, 16'sd0, 1);
        applyStimulus(0, 0, 16'sd0, 0);
        buildLinear(0);
        play(0, -1);

        // Mid-check start pulse and 3-cycle gaps.
        buildLinear(0);
        stim_q[SKIP + 9] = 777;
        play(3, SKIP + 6);

        // Randomised runs: small offsets, occasional wild samples, random
        // gaps, random stray start pulses and an occasional early reset.
        for (int r = 0; r < 10; r++) begin
            stim_q.delete();
            for (int i = 0; i < SKIP; i++) stim_q.push_back(int'($signed(16'($urandom))));
            for (int i = 0; i < DEPTH; i++) begin
                if ($urandom_range(0, 7) == 0) stim_q.push_back(int'($signed(16'($urandom))));
                else stim_q.push_back(i * 100 + int'($urandom_range(0, 6)) - 3);
            end
            play(int'($urandom_range(0, 2)), int'($urandom_range(0, 30)));
            if ($urandom_range(0, 3) == 0) begin
                applyStimulus(1, 0, 16'sd0, 0);
                for (int i = 0; i < 8; i++) applyStimulus(0, 1, 16'($urandom), 0);
                applyStimulus(0, 1, 16'($urandom), 1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
